idli_slice_buf_m: RTL

IDLI_SLICE_BUF_M -- requirements
Module: idli_slice_buf_m

---
 rtl/idli_pkg.sv | 29 ++
 rtl/idli_slice_buf_m_if.sv | 58 +++++
 rtl/idli_slice_sel_m.sv | 29 ++
 rtl/idli_slice_buf_m.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared types for the slice-streaming buffer.
// word_t is the full operand word; slice_t/ctr_t describe one 4-bit slice
// and its index; sbuf_state_t is the buffer sequencer state.
package idli_pkg;

   localparam int WORD_W   = 16;
   localparam int SLICE_W  = 4;
   localparam int N_SLICES = WORD_W / SLICE_W;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [SLICE_W-1:0] slice_t;
   typedef logic [1:0]         ctr_t;
   typedef logic [3:0]         bit_idx_t;

   typedef enum logic [1:0] {
      SBUF_IDLE   = 2'd0,
      SBUF_STREAM = 2'd1,
      SBUF_HOLD   = 2'd2
   } sbuf_state_t;

   // Index of the slice counter's last value (wraps back to 0 afterwards).
   localparam ctr_t CTR_LAST = ctr_t'(N_SLICES - 1);

   // Bit position of the least significant bit of slice number c.
   function automatic bit_idx_t slice_lsb(input ctr_t c);
      return {c, 2'b00};
   endfunction

endpackage

// File: rtl/idli_slice_buf_m_if.sv
// idli_slice_buf_m_if: handshake and data bundle of the slice buffer.
// slave  : the buffer itself (consumes i_*, drives o_*).
// master : the environment around it (producer, slice consumer, sink).
interface idli_slice_buf_m_if;
   import idli_pkg::*;

   // word input handshake
   logic   i_sbuf_in_vld;
   logic   o_sbuf_in_rdy;
   word_t  i_sbuf_in_data;
   logic   i_sbuf_flush;

   // slice stream towards the consumer
   ctr_t   o_sbuf_ctr;
   slice_t o_sbuf_slice;
   logic   o_sbuf_next;
   logic   o_sbuf_prev;
   logic   o_sbuf_busy;
   slice_t i_sbuf_res;

   // assembled result handshake
   logic   o_sbuf_out_vld;
   logic   i_sbuf_out_rdy;
   word_t  o_sbuf_out_data;

   modport slave (
      input  i_sbuf_in_vld,
      input  i_sbuf_in_data,
      input  i_sbuf_flush,
      input  i_sbuf_res,
      input  i_sbuf_out_rdy,
      output o_sbuf_in_rdy,
      output o_sbuf_ctr,
      output o_sbuf_slice,
      output o_sbuf_next,
      output o_sbuf_prev,
      output o_sbuf_busy,
      output o_sbuf_out_vld,
      output o_sbuf_out_data
   );

   modport master (
      output i_sbuf_in_vld,
      output i_sbuf_in_data,
      output i_sbuf_flush,
      output i_sbuf_res,
      output i_sbuf_out_rdy,
      input  o_sbuf_in_rdy,
      input  o_sbuf_ctr,
      input  o_sbuf_slice,
      input  o_sbuf_next,
      input  o_sbuf_prev,
      input  o_sbuf_busy,
      input  o_sbuf_out_vld,
      input  o_sbuf_out_data
   );

endinterface

// File: rtl/idli_slice_sel_m.sv
// idli_slice_sel_m: purely combinational slice picker.
// Returns slice number i_ctr of i_word together with the neighbouring bits:
// o_next is the LSB of the following slice, o_prev the MSB of the preceding
// one, both wrapping around the 16-bit word.
module idli_slice_sel_m
   import idli_pkg::*;
(
   input  word_t  i_word,
   input  ctr_t   i_ctr,
   output slice_t o_slice,
   output logic   o_next,
   output logic   o_prev
);

   bit_idx_t lsb_idx;
   bit_idx_t next_idx;
   bit_idx_t prev_idx;

   // 4-bit index arithmetic wraps modulo 16, giving the ring neighbours for free.
   always_comb begin
      lsb_idx  = slice_lsb(i_ctr);
      next_idx = lsb_idx + bit_idx_t'(SLICE_W);
      prev_idx = lsb_idx - bit_idx_t'(1);
      o_slice  = i_word[lsb_idx +: SLICE_W];
      o_next   = i_word[next_idx];
      o_prev   = i_word[prev_idx];
   end

endmodule

// File: rtl/idli_slice_buf_m.sv
// idli_slice_buf_m: streams a 16-bit word out as four 4-bit slices (LSB
// slice first), collects the consumer's 4-bit answer for each slice and
// presents the reassembled 16-bit result on a valid/ready output.
//
// Sequencer: IDLE -> STREAM (4 cycles, one slice each) -> HOLD (result
// valid until taken). i_sbuf_flush aborts STREAM/HOLD and discards the word.
//
// Build option: define IDLI_SBUF_B2B_EN to let a new word be accepted in the
// same cycle the held result is taken, removing the IDLE bubble between
// words. Without it, in_rdy stays low in HOLD.
module idli_slice_buf_m
   import idli_pkg::*;
(
   input  logic              i_sbuf_gck,
   input  logic              i_sbuf_rst_n,
   idli_slice_buf_m_if.slave sbuf
);

   sbuf_state_t state_q;
   sbuf_state_t state_d;

   word_t  src_q;
   word_t  res_q;
   ctr_t   ctr_q;

   logic   load_word;
   logic   stream_step;
   logic   drop_word;

   ctr_t   sel_ctr;
   slice_t sel_slice;
   logic   sel_next;
   logic   sel_prev;

   // State register.
   always_ff @(posedge i_sbuf_gck) begin
      if (!i_sbuf_rst_n) begin
         state_q <= SBUF_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: flush outranks every other event outside IDLE.
   always_comb begin
      state_d   = state_q;
      load_word = 1'b0;
      unique case (state_q)
         SBUF_IDLE: begin
            if (sbuf.i_sbuf_in_vld) begin
               state_d   = SBUF_STREAM;
               load_word = 1'b1;
            end
         end
         SBUF_STREAM: begin
            if (sbuf.i_sbuf_flush) begin
               state_d = SBUF_IDLE;
            end else if (ctr_q == CTR_LAST) begin
               state_d = SBUF_HOLD;
            end
         end
         SBUF_HOLD: begin
            if (sbuf.i_sbuf_flush) begin
               state_d = SBUF_IDLE;
            end else if (sbuf.i_sbuf_out_rdy) begin
`ifdef IDLI_SBUF_B2B_EN
               if (sbuf.i_sbuf_in_vld) begin
                  state_d   = SBUF_STREAM;
                  load_word = 1'b1;
               end else begin
                  state_d = SBUF_IDLE;
               end
`else
               state_d = SBUF_IDLE;
`endif
            end
         end
         default: begin
            state_d = SBUF_IDLE;
         end
      endcase
   end

   // Control outputs decoded from the current state.
   always_comb begin
      sbuf.o_sbuf_in_rdy  = 1'b0;
      sbuf.o_sbuf_busy    = 1'b0;
      sbuf.o_sbuf_out_vld = 1'b0;
      stream_step         = 1'b0;
      drop_word           = 1'b0;
      unique case (state_q)
         SBUF_IDLE: begin
            sbuf.o_sbuf_in_rdy = 1'b1;
         end
         SBUF_STREAM: begin
            sbuf.o_sbuf_busy = 1'b1;
            stream_step      = !sbuf.i_sbuf_flush;
            drop_word        = sbuf.i_sbuf_flush;
         end
         SBUF_HOLD: begin
            sbuf.o_sbuf_out_vld = 1'b1;
            drop_word           = sbuf.i_sbuf_flush;
`ifdef IDLI_SBUF_B2B_EN
            // A flush blocks the hand-over, so ready must drop with it.
            sbuf.o_sbuf_in_rdy  = sbuf.i_sbuf_out_rdy && !sbuf.i_sbuf_flush;
`endif
         end
         default: begin
            sbuf.o_sbuf_in_rdy = 1'b0;
         end
      endcase
   end

   // Source word, result assembly and slice counter.
   always_ff @(posedge i_sbuf_gck) begin
      if (!i_sbuf_rst_n) begin
         src_q <= '0;
         res_q <= '0;
         ctr_q <= '0;
      end else if (drop_word) begin
         res_q <= '0;
         ctr_q <= '0;
      end else if (load_word) begin
         src_q <= sbuf.i_sbuf_in_data;
         ctr_q <= '0;
      end else if (stream_step) begin
         // Last slice wraps the counter back to 0 for the next word.
         res_q[slice_lsb(ctr_q) +: SLICE_W] <= sbuf.i_sbuf_res;
         ctr_q                              <= ctr_q + ctr_t'(1);
      end
   end

   // Outside STREAM the selector is pinned to slice 0 of the source word.
   always_comb begin
      sel_ctr = (state_q == SBUF_STREAM) ? ctr_q : '0;
   end

   idli_slice_sel_m u_slice_sel (
      .i_word  (src_q),
      .i_ctr   (sel_ctr),
      .o_slice (sel_slice),
      .o_next  (sel_next),
      .o_prev  (sel_prev)
   );

   // Data outputs.
   always_comb begin
      sbuf.o_sbuf_ctr      = ctr_q;
      sbuf.o_sbuf_slice    = sel_slice;
      sbuf.o_sbuf_next     = sel_next;
      sbuf.o_sbuf_prev     = sel_prev;
      sbuf.o_sbuf_out_data = res_q;
   end

endmodule
